// File: rtl/control_unit_gen_if.sv
// -----------------------------------------------------------------------------
// control_unit_gen_if
//   Data-memory handshake between the control unit and the data memory.
//   One request is outstanding at a time; the memory finishes it by raising
//   d_ready for a single cycle while d_req is high.
//
//   Signals:
//     d_req    control unit -> memory   access request
//     d_wr     control unit -> memory   1 = write, 0 = read
//     d_addr   control unit -> memory   access address (DAW bits)
//     d_ready  memory -> control unit   current access completes this cycle
//
//   Modports:
//     master   used by the control unit
//     slave    used by the data memory (or a bench model of it)
// -----------------------------------------------------------------------------
interface control_unit_gen_if #(
   parameter int DAW = 8
);
   logic           d_req;
   logic           d_wr;
   logic [DAW-1:0] d_addr;
   logic           d_ready;

   modport master (
      output d_req,
      output d_wr,
      output d_addr,
      input  d_ready
   );

   modport slave (
      input  d_req,
      input  d_wr,
      input  d_addr,
      output d_ready
   );
endinterface : control_unit_gen_if

// File: rtl/control_unit_gen.sv
// -----------------------------------------------------------------------------
// control_unit_gen
//   Multi-cycle control unit for the single-issue datapath (PC, IR, register
//   file, ALU, data memory). Sequences FETCH -> DECODE -> execute for NOOP,
//   STORE, LOAD, ADD, SUB, HALT, JMP and JZ. Data-memory accesses wait on a
//   req/ready handshake with an optional timeout that parks the unit in HALT
//   and raises a sticky error flag. Retired instructions are counted with a
//   saturating counter.
//
//   Instruction layout (IW = OPW + 3*RAW):
//     op = [IW-1 -: OPW]   A = [3RAW-1 -: RAW]   B = [2RAW-1 -: RAW]
//     W  = [RAW-1:0]       M = [DAW-1:0] (STORE/JMP/JZ)   L = [3RAW-1 -: DAW] (LOAD)
//
//   Ports:
//     clk          clock
//     reset        synchronous, active-low
//     instr        IR contents, valid from DECODE onward
//     alu_zero     ALU result equals zero (JZ condition)
//     mem          data-memory handshake (master side)
//     pc_clr       clear PC                  pc_up      increment PC
//     pc_ld        load PC from pc_target    pc_target  jump target
//     ir_ld        load IR
//     rf_s         write-back select: 1 = memory, 0 = ALU
//     rf_w_en      register-file write enable
//     rf_w_addr    write address   rf_ra_addr / rf_rb_addr  read addresses
//     alu_sel      0 idle, 1 ADD, 2 SUB, 3 PASS_A
//     halted       high in HALT
//     err          sticky memory-timeout flag
//     instr_count  saturating retired-instruction count
//     state_out    current state encoding (debug)
// -----------------------------------------------------------------------------
module control_unit_gen #(
   parameter  int OPW      = 4,
   parameter  int RAW      = 4,
   parameter  int ALUW     = 3,
   parameter  int WAIT_MAX = 8,
   parameter  int CNTW     = 16,
   localparam int DAW      = 2 * RAW,
   localparam int IW       = OPW + 3 * RAW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IW-1:0]       instr,
   input  logic                alu_zero,
   control_unit_gen_if.master  mem,
   output logic                pc_clr,
   output logic                pc_up,
   output logic                pc_ld,
   output logic [DAW-1:0]      pc_target,
   output logic                ir_ld,
   output logic                rf_s,
   output logic                rf_w_en,
   output logic [RAW-1:0]      rf_w_addr,
   output logic [RAW-1:0]      rf_ra_addr,
   output logic [RAW-1:0]      rf_rb_addr,
   output logic [ALUW-1:0]     alu_sel,
   output logic                halted,
   output logic                err,
   output logic [CNTW-1:0]     instr_count,
   output logic [3:0]          state_out
);

   // ---------------------------------------------------------------------------
   // State encoding is visible on state_out, so every value is pinned.
   // ---------------------------------------------------------------------------
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LD_REQ = 4'd4,
      S_LD_WB  = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_JMP    = 4'd9,
      S_JZ     = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
   localparam logic [OPW-1:0] OP_STORE = OPW'(1);
   localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
   localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
   localparam logic [OPW-1:0] OP_HALT  = OPW'(5);
   localparam logic [OPW-1:0] OP_JMP   = OPW'(6);
   localparam logic [OPW-1:0] OP_JZ    = OPW'(7);

   localparam logic [ALUW-1:0] ALU_IDLE = ALUW'(0);
   localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(1);
   localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(2);
   localparam logic [ALUW-1:0] ALU_PASS = ALUW'(3);

   // The wait counter only needs to reach WAIT_MAX-1: on that cycle the unit
   // either completes or times out, and both leave the wait state.
   localparam int              WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WCW-1:0]  WAIT_LAST = (WAIT_MAX > 0) ? WCW'(WAIT_MAX - 1) : '0;
   localparam logic [CNTW-1:0] CNT_MAX   = '1;

   // ---------------------------------------------------------------------------
   // Instruction fields
   // ---------------------------------------------------------------------------
   logic [OPW-1:0] op;
   logic [RAW-1:0] f_a;
   logic [RAW-1:0] f_b;
   logic [RAW-1:0] f_w;
   logic [DAW-1:0] f_m;
   logic [DAW-1:0] f_l;

   assign op  = instr[IW-1 -: OPW];
   assign f_a = instr[3*RAW-1 -: RAW];
   assign f_b = instr[2*RAW-1 -: RAW];
   assign f_w = instr[RAW-1:0];
   assign f_m = instr[DAW-1:0];
   assign f_l = instr[3*RAW-1 -: DAW];

   // ---------------------------------------------------------------------------
   // State and status registers
   // ---------------------------------------------------------------------------
   state_t         state;
   state_t         next_state;
   logic [WCW-1:0] wait_cnt;

   // Local copies of the handshake outputs, driven onto the interface below.
   logic           d_req;
   logic           d_wr;
   logic [DAW-1:0] d_addr;

   logic           in_wait;      // LD_REQ or STORE: waiting on the memory
   logic           wait_expired; // counter sits on its last allowed value
   logic           timeout_hit;  // give up on the access at this edge
   logic           stall;        // remain in the wait state at this edge
   logic           retire;       // an instruction completes at this edge

   assign in_wait      = (state == S_LD_REQ) || (state == S_STORE);
   assign wait_expired = (WAIT_MAX > 0) && (wait_cnt == WAIT_LAST);
   assign timeout_hit  = in_wait && !mem.d_ready && wait_expired;
   assign stall        = in_wait && !mem.d_ready && !wait_expired;

   // Only execute states ever hand over to FETCH apart from INIT, so "into
   // FETCH, not from INIT" is exactly the set of retiring transitions.
   assign retire = (next_state == S_FETCH) && (state != S_INIT);

   // ---------------------------------------------------------------------------
   // Next-state and decode outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets its default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      next_state = state;
      pc_clr     = 1'b0;
      pc_up      = 1'b0;
      pc_ld      = 1'b0;
      pc_target  = '0;
      ir_ld      = 1'b0;
      d_req      = 1'b0;
      d_wr       = 1'b0;
      d_addr     = '0;
      rf_s       = 1'b0;
      rf_w_en    = 1'b0;
      rf_w_addr  = '0;
      rf_ra_addr = '0;
      rf_rb_addr = '0;
      alu_sel    = ALU_IDLE;
      halted     = 1'b0;

      case (state)
         S_INIT: begin
            pc_clr     = 1'b1;
            next_state = S_FETCH;
         end

         S_FETCH: begin
            pc_up      = 1'b1;
            ir_ld      = 1'b1;
            next_state = S_DECODE;
         end

         S_DECODE: begin
            case (op)
               OP_NOOP:  next_state = S_NOOP;
               OP_STORE: next_state = S_STORE;
               OP_LOAD:  next_state = S_LD_REQ;
               OP_ADD:   next_state = S_ADD;
               OP_SUB:   next_state = S_SUB;
               OP_HALT:  next_state = S_HALT;
               OP_JMP:   next_state = S_JMP;
               OP_JZ:    next_state = S_JZ;
               default:  next_state = S_NOOP;
            endcase
         end

         S_NOOP: begin
            next_state = S_FETCH;
         end

         S_LD_REQ: begin
            d_req     = 1'b1;
            d_addr    = f_l;
            rf_s      = 1'b1;
            rf_w_addr = f_w;
            // A ready on the last allowed cycle still completes the load.
            if (mem.d_ready) begin
               next_state = S_LD_WB;
            end else if (wait_expired) begin
               next_state = S_HALT;
            end
         end

         S_LD_WB: begin
            d_addr     = f_l;
            rf_s       = 1'b1;
            rf_w_addr  = f_w;
            rf_w_en    = 1'b1;
            next_state = S_FETCH;
         end

         S_STORE: begin
            d_req      = 1'b1;
            d_wr       = 1'b1;
            d_addr     = f_m;
            rf_ra_addr = f_a;
            if (mem.d_ready) begin
               next_state = S_FETCH;
            end else if (wait_expired) begin
               next_state = S_HALT;
            end
         end

         S_ADD, S_SUB: begin
            rf_ra_addr = f_a;
            rf_rb_addr = f_b;
            rf_w_addr  = f_w;
            rf_w_en    = 1'b1;
            alu_sel    = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            next_state = S_FETCH;
         end

         S_JMP: begin
            pc_ld      = 1'b1;
            pc_target  = f_m;
            next_state = S_FETCH;
         end

         S_JZ: begin
            // ALU passes A through so alu_zero reflects the register itself;
            // when not taken the PC keeps the increment done in FETCH.
            rf_ra_addr = f_a;
            alu_sel    = ALU_PASS;
            pc_target  = f_m;
            pc_ld      = alu_zero;
            next_state = S_FETCH;
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: begin
            next_state = S_INIT;
         end
      endcase
   end

   assign mem.d_req  = d_req;
   assign mem.d_wr   = d_wr;
   assign mem.d_addr = d_addr;
   assign state_out  = state;

   // ---------------------------------------------------------------------------
   // Registers: synchronous active-low reset overrides everything, including
   // a pending memory wait and HALT.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every update in this
      // block sees the pre-edge values, independent of statement order.
      if (!reset) begin
         state       <= S_INIT;
         err         <= 1'b0;
         instr_count <= '0;
         wait_cnt    <= '0;
      end else begin
         state <= next_state;

         if (timeout_hit) begin
            err <= 1'b1;
         end

         if (retire && (instr_count != CNT_MAX)) begin
            instr_count <= instr_count + CNTW'(1);
         end

         // Counts stalled cycles of the current access; any exit clears it.
         if (stall && (WAIT_MAX > 0)) begin
            wait_cnt <= wait_cnt + WCW'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end

endmodule : control_unit_gen

// File: tb/tb_control_unit_gen.sv
// -----------------------------------------------------------------------------
// tb_control_unit_gen
//   Bench for control_unit_gen with default parameters (16-bit instructions,
//   WAIT_MAX = 8). A second instance with a 2-bit instruction counter runs on
//   the same stimulus to exercise counter saturation.
//   Directed cycle-by-cycle table, a few hand sequences around the memory
//   timeout and reset, then random instructions checked against an
//   instruction-level model that expands each instruction into its expected
//   per-cycle output trace.
// -----------------------------------------------------------------------------
module tb_control_unit_gen;

   localparam int WAIT_MAX = 8;
   localparam int SAT_MAX  = 3;   // 2-bit counter in the second instance

   typedef struct packed {
      logic [3:0] st;
      logic       pc_clr;
      logic       pc_up;
      logic       pc_ld;
      logic [7:0] pc_target;
      logic       ir_ld;
      logic       d_req;
      logic       d_wr;
      logic [7:0] d_addr;
      logic       rf_s;
      logic       rf_w_en;
      logic [3:0] wa;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic       halted;
      logic       err;
      logic [15:0] cnt;
   } outs_t;

   typedef struct {
      string       nm;
      logic [15:0] i;
      logic        rdy;
      logic        z;
      outs_t       e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        d_ready;
   logic        alu_zero;

   always #5 clk = ~clk;

   // Main instance
   logic       pc_clr, pc_up, pc_ld, ir_ld, rf_s, rf_w_en, halted, err;
   logic [7:0] pc_target;
   logic [3:0] rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
   logic [2:0] alu_sel;
   logic [15:0] instr_count;

   control_unit_gen_if #(.DAW(8)) mem_if ();
   assign mem_if.d_ready = d_ready;

   control_unit_gen dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .mem        (mem_if),
      .pc_clr     (pc_clr),
      .pc_up      (pc_up),
      .pc_ld      (pc_ld),
      .pc_target  (pc_target),
      .ir_ld      (ir_ld),
      .rf_s       (rf_s),
      .rf_w_en    (rf_w_en),
      .rf_w_addr  (rf_w_addr),
      .rf_ra_addr (rf_ra_addr),
      .rf_rb_addr (rf_rb_addr),
      .alu_sel    (alu_sel),
      .halted     (halted),
      .err        (err),
      .instr_count(instr_count),
      .state_out  (state_out)
   );

   // Saturation instance: only its counter is compared.
   logic       s_pc_clr, s_pc_up, s_pc_ld, s_ir_ld, s_rf_s, s_rf_w_en, s_halted, s_err;
   logic [7:0] s_pc_target;
   logic [3:0] s_rf_w_addr, s_rf_ra_addr, s_rf_rb_addr, s_state_out;
   logic [2:0] s_alu_sel;
   logic [1:0] s_instr_count;

   control_unit_gen_if #(.DAW(8)) mem_s ();
   assign mem_s.d_ready = d_ready;

   control_unit_gen #(.CNTW(2)) dut_s (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .mem        (mem_s),
      .pc_clr     (s_pc_clr),
      .pc_up      (s_pc_up),
      .pc_ld      (s_pc_ld),
      .pc_target  (s_pc_target),
      .ir_ld      (s_ir_ld),
      .rf_s       (s_rf_s),
      .rf_w_en    (s_rf_w_en),
      .rf_w_addr  (s_rf_w_addr),
      .rf_ra_addr (s_rf_ra_addr),
      .rf_rb_addr (s_rf_rb_addr),
      .alu_sel    (s_alu_sel),
      .halted     (s_halted),
      .err        (s_err),
      .instr_count(s_instr_count),
      .state_out  (s_state_out)
   );

   outs_t obs;
   always_comb begin
      obs           = '0;
      obs.st        = state_out;
      obs.pc_clr    = pc_clr;
      obs.pc_up     = pc_up;
      obs.pc_ld     = pc_ld;
      obs.pc_target = pc_target;
      obs.ir_ld     = ir_ld;
      obs.d_req     = mem_if.d_req;
      obs.d_wr      = mem_if.d_wr;
      obs.d_addr    = mem_if.d_addr;
      obs.rf_s      = rf_s;
      obs.rf_w_en   = rf_w_en;
      obs.wa        = rf_w_addr;
      obs.ra        = rf_ra_addr;
      obs.rb        = rf_rb_addr;
      obs.alu       = alu_sel;
      obs.halted    = halted;
      obs.err       = err;
      obs.cnt       = instr_count;
   end

   int total = 0;
   int bad   = 0;

   // Model status
   logic m_err = 1'b0;
   int   m_cnt = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   function automatic outs_t mk(input int st);
      outs_t e;
      e     = '0;
      e.st  = 4'(st);
      e.err = m_err;
      e.cnt = 16'(m_cnt);
      return e;
   endfunction

   function automatic logic rnd_bit();
      return logic'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs on the falling edge, compare 1 ns later.
   task automatic cycle(input string nm, input logic [15:0] i, input logic rdy,
                        input logic z, input outs_t e);
      int sat;
      @(negedge clk);
      instr    = i;
      d_ready  = rdy;
      alu_zero = z;
      #1;
      sat = (int'(e.cnt) > SAT_MAX) ? SAT_MAX : int'(e.cnt);
      check(nm, 64'(obs), 64'(e));
      check({nm, "_satcnt"}, 64'(s_instr_count), 64'(sat));
   endtask

   // Hold reset for n rising edges, check the INIT outputs, then release.
   task automatic do_reset(input int n);
      outs_t e;
      @(negedge clk);
      reset    = 1'b0;
      instr    = '0;
      d_ready  = 1'b0;
      alu_zero = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
      m_err    = 1'b0;
      m_cnt    = 0;
      e        = mk(0);
      e.pc_clr = 1'b1;
      check("reset_init", 64'(obs), 64'(e));
      check("reset_satcnt", 64'(s_instr_count), 64'(0));
      reset = 1'b1;
   endtask

   task automatic retire();
      if (m_cnt < 65535) m_cnt++;
   endtask

   // Instruction-level model: expands one instruction into the cycles it
   // should take. k = number of cycles the memory holds d_ready low.
   task automatic run_instr(input logic [15:0] i, input int k, output bit hit_halt);
      int    iv, op, fa, fb, fw, fm, fl;
      outs_t e;
      logic  rdy, z;
      iv = int'(i);
      op = iv / 4096;
      fa = (iv / 256) % 16;
      fb = (iv / 16) % 16;
      fw = iv % 16;
      fm = iv % 256;
      fl = (iv / 16) % 256;
      hit_halt = 1'b0;

      e = mk(1); e.pc_up = 1'b1; e.ir_ld = 1'b1;
      cycle("fetch", i, rnd_bit(), rnd_bit(), e);
      e = mk(2);
      cycle("decode", i, rnd_bit(), rnd_bit(), e);

      case (op)
         1: begin
            for (int w = 0; w < WAIT_MAX; w++) begin
               rdy = (w >= k);
               e = mk(6); e.d_req = 1'b1; e.d_wr = 1'b1; e.d_addr = 8'(fm); e.ra = 4'(fa);
               cycle("store", i, rdy, rnd_bit(), e);
               if (rdy) begin
                  retire();
                  break;
               end
               if (w == WAIT_MAX - 1) begin
                  m_err = 1'b1;
                  hit_halt = 1'b1;
               end
            end
         end
         2: begin
            for (int w = 0; w < WAIT_MAX; w++) begin
               rdy = (w >= k);
               e = mk(4); e.d_req = 1'b1; e.d_addr = 8'(fl); e.rf_s = 1'b1; e.wa = 4'(fw);
               cycle("ld_req", i, rdy, rnd_bit(), e);
               if (rdy) break;
               if (w == WAIT_MAX - 1) begin
                  m_err = 1'b1;
                  hit_halt = 1'b1;
               end
            end
            if (!hit_halt) begin
               e = mk(5); e.d_addr = 8'(fl); e.rf_s = 1'b1; e.wa = 4'(fw); e.rf_w_en = 1'b1;
               cycle("ld_wb", i, rnd_bit(), rnd_bit(), e);
               retire();
            end
         end
         3, 4: begin
            e = mk(op == 3 ? 7 : 8);
            e.ra = 4'(fa); e.rb = 4'(fb); e.wa = 4'(fw); e.rf_w_en = 1'b1;
            e.alu = (op == 3) ? 3'd1 : 3'd2;
            cycle(op == 3 ? "add" : "sub", i, rnd_bit(), rnd_bit(), e);
            retire();
         end
         5: hit_halt = 1'b1;
         6: begin
            e = mk(9); e.pc_ld = 1'b1; e.pc_target = 8'(fm);
            cycle("jmp", i, rnd_bit(), rnd_bit(), e);
            retire();
         end
         7: begin
            z = rnd_bit();
            e = mk(10); e.ra = 4'(fa); e.alu = 3'd3; e.pc_target = 8'(fm); e.pc_ld = z;
            cycle("jz", i, rnd_bit(), z, e);
            retire();
         end
         default: begin
            e = mk(3);
            cycle("noop", i, rnd_bit(), rnd_bit(), e);
            retire();
         end
      endcase

      if (hit_halt) begin
         for (int h = 0; h < 2; h++) begin
            e = mk(11); e.halted = 1'b1;
            cycle("halt", i, rnd_bit(), rnd_bit(), e);
         end
      end
   endtask

   vec_t tbl[$];

   task automatic add(input string nm, input logic [15:0] i, input logic rdy,
                      input logic z, input outs_t e);
      vec_t v;
      v.nm = nm; v.i = i; v.rdy = rdy; v.z = z; v.e = e;
      tbl.push_back(v);
   endtask

   // Expected values for the directed table are written out by hand.
   function automatic outs_t o(input int st, input int cnt);
      outs_t e;
      e     = '0;
      e.st  = 4'(st);
      e.cnt = 16'(cnt);
      return e;
   endfunction

   task automatic fetch_decode(input logic [15:0] i, input int cnt);
      outs_t e;
      e = o(1, cnt); e.pc_up = 1'b1; e.ir_ld = 1'b1;
      add("t_fetch", i, 1'b0, 1'b0, e);
      add("t_decode", i, 1'b0, 1'b0, o(2, cnt));
   endtask

   task automatic build_table();
      outs_t e;
      fetch_decode(16'h0000, 0);
      add("t_noop", 16'h0000, 1'b0, 1'b0, o(3, 0));
      // LOAD 0x20A7, ready on the 4th LD_REQ cycle
      fetch_decode(16'h20A7, 1);
      for (int c = 0; c < 4; c++) begin
         e = o(4, 1); e.d_req = 1'b1; e.d_addr = 8'h0A; e.rf_s = 1'b1; e.wa = 4'd7;
         add("t_ld_req", 16'h20A7, (c == 3), 1'b0, e);
      end
      e = o(5, 1); e.d_addr = 8'h0A; e.rf_s = 1'b1; e.wa = 4'd7; e.rf_w_en = 1'b1;
      add("t_ld_wb", 16'h20A7, 1'b0, 1'b0, e);
      // STORE 0x1F29, immediate ready
      fetch_decode(16'h1F29, 2);
      e = o(6, 2); e.d_req = 1'b1; e.d_wr = 1'b1; e.d_addr = 8'h29; e.ra = 4'd15;
      add("t_store", 16'h1F29, 1'b1, 1'b0, e);
      // ADD 0x3123 / SUB 0x4123
      fetch_decode(16'h3123, 3);
      e = o(7, 3); e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd3; e.rf_w_en = 1'b1; e.alu = 3'd1;
      add("t_add", 16'h3123, 1'b0, 1'b0, e);
      fetch_decode(16'h4123, 4);
      e = o(8, 4); e.ra = 4'd1; e.rb = 4'd2; e.wa = 4'd3; e.rf_w_en = 1'b1; e.alu = 3'd2;
      add("t_sub", 16'h4123, 1'b0, 1'b0, e);
      // JZ 0x7340 taken, then not taken
      fetch_decode(16'h7340, 5);
      e = o(10, 5); e.ra = 4'd3; e.alu = 3'd3; e.pc_target = 8'h40; e.pc_ld = 1'b1;
      add("t_jz_taken", 16'h7340, 1'b0, 1'b1, e);
      fetch_decode(16'h7340, 6);
      e = o(10, 6); e.ra = 4'd3; e.alu = 3'd3; e.pc_target = 8'h40;
      add("t_jz_not", 16'h7340, 1'b1, 1'b0, e);
      // JMP 0x6055
      fetch_decode(16'h6055, 7);
      e = o(9, 7); e.pc_ld = 1'b1; e.pc_target = 8'h55;
      add("t_jmp", 16'h6055, 1'b0, 1'b0, e);
      // Undefined opcode behaves as NOOP
      fetch_decode(16'hF123, 8);
      add("t_undef_noop", 16'hF123, 1'b1, 1'b1, o(3, 8));
      e = o(1, 9); e.pc_up = 1'b1; e.ir_ld = 1'b1;
      add("t_fetch_end", 16'h0000, 1'b0, 1'b0, e);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit    h;
      outs_t e;
      reset    = 1'b0;
      instr    = '0;
      d_ready  = 1'b0;
      alu_zero = 1'b0;

      // Directed table
      do_reset(2);
      build_table();
      foreach (tbl[n]) begin
         cycle(tbl[n].nm, tbl[n].i, tbl[n].rdy, tbl[n].z, tbl[n].e);
      end

      // STORE never acknowledged: 8 wait cycles then HALT with err, reset clears.
      do_reset(1);
      run_instr(16'h1F29, 100, h);
      check("store_timeout_halted", 64'(h), 64'(1));
      do_reset(1);

      // LOAD acknowledged on the last allowed cycle completes without error.
      run_instr(16'h20A7, WAIT_MAX - 1, h);
      check("load_last_cycle_ok", 64'(h), 64'(0));
      // One cycle later it times out.
      run_instr(16'h20A7, WAIT_MAX, h);
      check("load_timeout_halted", 64'(h), 64'(1));
      do_reset(2);

      // Reset in the middle of a LOAD wait.
      e = mk(1); e.pc_up = 1'b1; e.ir_ld = 1'b1;
      cycle("mid_fetch", 16'h2345, 1'b0, 1'b0, e);
      cycle("mid_decode", 16'h2345, 1'b0, 1'b0, mk(2));
      for (int c = 0; c < 3; c++) begin
         e = mk(4); e.d_req = 1'b1; e.d_addr = 8'h34; e.rf_s = 1'b1; e.wa = 4'd5;
         cycle("mid_ld_req", 16'h2345, 1'b0, 1'b0, e);
      end
      do_reset(1);

      // Random instruction stream
      for (int n = 0; n < 400; n++) begin
         run_instr(16'($urandom), $urandom_range(0, WAIT_MAX + 1), h);
         if (h) do_reset($urandom_range(1, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_control_unit_gen
